// File: rtl/reg_file_pkg.sv
// Shared definitions for the register-file debug dump unit.
package reg_file_pkg;

    localparam int REG_W  = 32;
    localparam int REG_AW = 4;
    localparam int NREG   = 16;

    localparam logic [REG_AW-1:0] SP = 4'd13;
    localparam logic [REG_AW-1:0] LR = 4'd14;
    localparam logic [REG_AW-1:0] PC = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        DONE
    } dump_state_t;

endpackage

// File: rtl/reg_file_dump_unit.sv
// Walks a register range over one register-file read port and streams each
// captured value, tagged with its address, on a valid/ready link.
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  IDLE  | waiting for start; read port released (rd_addr = 0)
//  FETCH | drive rd_addr = cur, capture rd_data at the edge
//  SEND  | out_valid high, captured beat held until out_ready
//  DONE  | one-cycle done pulse after the final handshake
module reg_file_dump_unit
    import reg_file_pkg::*;
#(
    parameter int W    = REG_W,
    parameter int AW   = REG_AW,
    parameter int NREG = reg_file_pkg::NREG
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] first_addr,
    input  logic [AW-1:0] last_addr,
    input  logic          abort,
    output logic [AW-1:0] rd_addr,
    input  logic [W-1:0]  rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    dump_state_t   state;
    dump_state_t   state_nxt;
    logic [AW-1:0] cur;
    logic [AW-1:0] last_q;
    logic [AW-1:0] cur_inc;

    // Range walk wraps from the top register back to R0.
    assign cur_inc = AW'((int'(cur) + 1) % NREG);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!abort && start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                state_nxt = abort ? IDLE : SEND;
            end
            SEND: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (out_ready) begin
                    state_nxt = out_last ? DONE : FETCH;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        rd_addr   = '0;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            FETCH: begin
                rd_addr = cur;
                busy    = 1'b1;
            end
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Range latch, address counter and the held output beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur      <= '0;
            last_q   <= '0;
            out_data <= '0;
            out_addr <= '0;
            out_last <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        cur    <= first_addr;
                        last_q <= last_addr;
                    end
                end
                FETCH: begin
                    if (abort) begin
                        out_last <= 1'b0;
                    end else begin
                        out_data <= rd_data;
                        out_addr <= cur;
                        out_last <= (cur == last_q);
                    end
                end
                SEND: begin
                    if (abort) begin
                        out_last <= 1'b0;
                    end else if (out_ready) begin
                        out_last <= 1'b0;
                        if (!out_last) begin
                            cur <= cur_inc;
                        end
                    end
                end
                DONE: begin
                    out_last <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_dump_unit.sv
// Scoreboard bench for reg_file_dump_unit: expected beats are queued when a
// dump is started and popped on each observed handshake.
module tb_reg_file_dump_unit;
    import reg_file_pkg::*;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  first_addr;
    logic [3:0]  last_addr;
    logic        abort;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_addr;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] regs [16];
    logic [31:0] pc_val;
    exp_t        exp_q [$];
    int          checks = 0;
    int          passes = 0;

    always #5 clk = ~clk;

    // PC advances every clock; other registers come from the bench's array.
    always @(posedge clk) begin
        if (reset) pc_val <= 32'h0;
        else       pc_val <= pc_val + 32'd1;
    end

    assign rd_data = (rd_addr == PC) ? pc_val : regs[rd_addr];

    reg_file_dump_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .abort      (abort),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    // Runs one dump from IDLE. Entered and left at #1 after a rising edge.
    task automatic run_dump(input logic [3:0] f, input logic [3:0] l,
                            input bit rnd, input int abort_at, input int inject_at,
                            output int done_at, output int done_cnt, output int hs_cnt);
        int          n;
        int          ncyc;
        int          sends;
        bit          aborted;
        bit          stall;
        bit          fin;
        logic [31:0] sd;
        logic [3:0]  sa;
        logic        sl;
        exp_t        e;
        n = int'(4'(l - f)) + 1;
        for (int i = 0; i < n; i++) begin
            e.addr = 4'(f + 4'(i));
            e.data = (e.addr == PC) ? pc_val + 32'd1 + 32'(2 * i) : regs[e.addr];
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
        done_at = 0; done_cnt = 0; hs_cnt = 0; sends = 0;
        aborted = 0; stall = 0; fin = 0;
        sd = '0; sa = '0; sl = 1'b0;
        start = 1'b1; first_addr = f; last_addr = l; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        first_addr = 4'($urandom);
        last_addr  = 4'($urandom);
        ncyc = 1;
        while (!fin && ncyc < 400) begin
            abort = 1'b0;
            start = 1'b0;
            if (stall && out_valid) begin
                checks++;
                if (out_data !== sd || out_addr !== sa || out_last !== sl)
                    $display("FAIL stall_hold: got %h/%h/%b expected %h/%h/%b",
                             out_data, out_addr, out_last, sd, sa, sl);
                else passes++;
            end
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = ncyc;
            end
            if (aborted || (done_cnt > 0 && !done)) begin
                fin = 1;
            end else begin
                if (inject_at != 0 && ncyc == inject_at) begin
                    start = 1'b1; first_addr = 4'd3; last_addr = 4'd3;
                end
                out_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
                if (out_valid) begin
                    sends++;
                    if (abort_at != 0 && sends == abort_at) begin
                        abort = 1'b1; out_ready = 1'b1; aborted = 1;
                    end else if (out_ready) begin
                        hs_cnt++;
                        checks++;
                        if (exp_q.size() == 0) begin
                            $display("FAIL extra_beat: got addr %h data %h expected no beat",
                                     out_addr, out_data);
                        end else begin
                            e = exp_q.pop_front();
                            if (out_addr !== e.addr || out_data !== e.data || out_last !== e.last)
                                $display("FAIL beat: got %h/%h/%b expected %h/%h/%b",
                                         out_addr, out_data, out_last, e.addr, e.data, e.last);
                            else passes++;
                        end
                    end
                end
                stall = out_valid && !out_ready && !aborted;
                sd = out_data; sa = out_addr; sl = out_last;
                @(posedge clk); #1;
                ncyc++;
            end
        end
        abort = 1'b0;
        start = 1'b0;
        if (!fin) begin
            checks++;
            $display("FAIL dump_timeout: got %0d cycles expected completion", ncyc);
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) $display("FAIL %s: got %0d expected %0d", name, got, want);
        else passes++;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        first_addr = '0; last_addr = '0;
        for (int i = 0; i < 16; i++) regs[i] = 32'h1000_0000 + 32'(i);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({out_valid, out_last, busy, done}), 0);
        chk("reset_data", int'(out_data) + int'(out_addr) + int'(rd_addr), 0);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_dump();
        int da, dc, hs;
        run_dump(4'd0, 4'd15, 0, 0, 0, da, dc, hs);
        chk("full_beats", hs, 16);
        chk("full_done_cycle", da, 33);
        chk("full_done_pulses", dc, 1);
        chk("full_queue_empty", exp_q.size(), 0);
    endtask

    task automatic test_wrap();
        int da, dc, hs;
        run_dump(4'd14, 4'd1, 0, 0, 0, da, dc, hs);
        chk("wrap_beats", hs, 4);
        chk("wrap_done_cycle", da, 9);
        chk("wrap_queue_empty", exp_q.size(), 0);
    endtask

    task automatic test_backpressure();
        int da, dc, hs;
        run_dump(4'd2, 4'd10, 1, 0, 0, da, dc, hs);
        chk("bp_beats", hs, 9);
        chk("bp_done_pulses", dc, 1);
        chk("bp_queue_empty", exp_q.size(), 0);
    endtask

    task automatic test_single();
        int da, dc, hs;
        regs[SP] = 32'hDEAD_BEEF;
        run_dump(SP, SP, 0, 0, 0, da, dc, hs);
        chk("single_beats", hs, 1);
        chk("single_done_cycle", da, 3);
        chk("single_queue_empty", exp_q.size(), 0);
    endtask

    task automatic test_abort();
        int da, dc, hs;
        run_dump(4'd0, 4'd7, 0, 3, 0, da, dc, hs);
        chk("abort_beats", hs, 2);
        chk("abort_no_done", dc, 0);
        chk("abort_valid_low", int'({out_valid, out_last, busy}), 0);
        chk("abort_pending", exp_q.size(), 6);
        exp_q.delete();
        run_dump(4'd5, 4'd5, 0, 0, 0, da, dc, hs);
        chk("post_abort_beats", hs, 1);
        chk("post_abort_done", dc, 1);
        chk("post_abort_queue", exp_q.size(), 0);
    endtask

    task automatic test_async_reset_ignored_start();
        int da, dc, hs;
        start = 1'b1; first_addr = 4'd0; last_addr = 4'd7; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_valid", int'(out_valid), 1);
        #3 reset = 1'b1;
        #1;
        chk("async_reset_clear", int'({out_valid, out_last, busy, done}), 0);
        chk("async_reset_rdaddr", int'(rd_addr), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("after_reset_idle", int'({out_valid, busy, done}), 0);
        run_dump(4'd4, 4'd9, 0, 0, 4, da, dc, hs);
        chk("ignored_start_beats", hs, 6);
        chk("ignored_start_done", da, 13);
        chk("ignored_start_queue", exp_q.size(), 0);
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_wrap();
        test_backpressure();
        test_single();
        test_abort();
        test_async_reset_ignored_start();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
